// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 types and helpers for the iterative decrypt core.
// Contents: 128-bit block type, FSM state enum, GF(2^8) arithmetic (poly 0x11B),
// forward/inverse S-box, rcon table, key-schedule steps and InvMixColumns column.
// The S-boxes are computed from the field inverse plus the affine map rather
// than stored, which keeps the table logic out of the source.
package aes_pkg;

   typedef logic [127:0] block_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      KEYEXP = 2'd1,
      DEC    = 2'd2,
      DONE   = 2'd3
   } state_t;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         p = p ^ (b[i] ? x : 8'h00);
         x = xtime(x);
      end
      return p;
   endfunction

   // a^254 == a^-1 in GF(2^8); maps 0 to 0 as the S-box requires
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] x;
      r = 8'h01;
      x = a;
      for (int i = 0; i < 7; i++) begin
         x = gmul(x, x);
         r = gmul(r, x);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   // inverse affine map (rotations by 1, 3, 6, constant 0x05) then field inverse
   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
   endfunction

   // round constants for rounds 1..10; other indices yield 0
   function automatic logic [7:0] rcon(input logic [3:0] idx);
      logic [7:0] r;
      case (idx)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   // round key r-1 -> round key r
   function automatic block_t key_fwd(input block_t k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3;
      w0 = k[127:96] ^ sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h000000};
      w1 = k[95:64] ^ w0;
      w2 = k[63:32] ^ w1;
      w3 = k[31:0]  ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   // round key r -> round key r-1, using rcon of round r
   function automatic block_t key_inv(input block_t k, input logic [7:0] rc);
      logic [31:0] b0, b1, b2, b3;
      b3 = k[31:0]  ^ k[63:32];
      b2 = k[63:32] ^ k[95:64];
      b1 = k[95:64] ^ k[127:96];
      b0 = k[127:96] ^ sub_word({b3[23:0], b3[31:24]}) ^ {rc, 24'h000000};
      return {b0, b1, b2, b3};
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      a0 = c[31:24];
      a1 = c[23:16];
      a2 = c[15:8];
      a3 = c[7:0];
      return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
              gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
              gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
              gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational AES inverse round.
// Ports: st (state in), rk (round key), last (1 = skip InvMixColumns),
//        result = [InvMixColumns](InvSubBytes(InvShiftRows(st)) ^ rk).
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [127:0] st,
   input  logic [127:0] rk,
   input  logic         last,
   output logic [127:0] result
);

   logic [127:0] add_s;
   logic [127:0] mix_s;

   // byte (r,c) of the output comes from byte (r,(c-r) mod 4) of the input
   always_comb begin
      add_s = 128'h0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            add_s[127-8*(r+4*c) -: 8] = inv_sbox(st[127-8*(r+4*((c+4-r)%4)) -: 8])
                                        ^ rk[127-8*(r+4*c) -: 8];
         end
      end
   end

   // column-wise InvMixColumns
   always_comb begin
      mix_s = 128'h0;
      for (int c = 0; c < 4; c++) begin
         mix_s[127-32*c -: 32] = inv_mix_col(add_s[127-32*c -: 32]);
      end
   end

   assign result = last ? add_s : mix_s;

endmodule

// File: rtl/aes_decrypt_core.sv
// aes_decrypt_core: iterative AES-128 inverse cipher, one inverse round per clock.
// Ports: i_clk/i_rst (async active-high), i_valid/o_ready/i_data/i_key (input
// handshake, ciphertext, key), o_valid/i_ready/o_data (output handshake, plaintext).
// Round keys are walked forward to k10, then backward to k0 while decrypting.
// The last key and its k10 are cached so a repeated key skips expansion.
module aes_decrypt_core
   import aes_pkg::*;
(
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [127:0] i_data,
   input  logic [127:0] i_key,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [127:0] o_data
);

   state_t       state_r, state_s;
   logic [127:0] st_r, st_s;
   logic [127:0] rk_r, rk_s;
   logic [127:0] ckey_r, ckey_s;
   logic [127:0] cache_key_r, cache_key_s;
   logic [127:0] cache_k10_r, cache_k10_s;
   logic [127:0] o_data_r, o_data_s;
   logic [3:0]   rnd_r, rnd_s;
   logic         cache_vld_r, cache_vld_s;
   logic         o_valid_r, o_valid_s;
   logic         o_ready_r, o_ready_s;
   logic [127:0] round_s, fwd_s, inv_s;
   logic         hit_s, last_s;

   assign fwd_s  = key_fwd(rk_r, rcon(rnd_r));
   assign inv_s  = key_inv(rk_r, rcon(rnd_r));
   assign hit_s  = cache_vld_r && (i_key == cache_key_r);
   assign last_s = (rnd_r == 4'd0);

   aes_inv_round u_round (
      .st     (st_r),
      .rk     (rk_r),
      .last   (last_s),
      .result (round_s)
   );

   // next-state and datapath update
   always_comb begin
      state_s     = state_r;
      st_s        = st_r;
      rk_s        = rk_r;
      rnd_s       = rnd_r;
      ckey_s      = ckey_r;
      cache_key_s = cache_key_r;
      cache_k10_s = cache_k10_r;
      cache_vld_s = cache_vld_r;
      o_data_s    = o_data_r;
      o_valid_s   = o_valid_r;
      o_ready_s   = o_ready_r;
      case (state_r)
         IDLE: begin
            if (i_valid) begin
               st_s      = i_data;
               ckey_s    = i_key;
               o_ready_s = 1'b0;
               if (hit_s) begin
                  rk_s    = cache_k10_r;
                  rnd_s   = 4'd10;
                  state_s = DEC;
               end else begin
                  rk_s    = i_key;
                  rnd_s   = 4'd1;
                  state_s = KEYEXP;
               end
            end else begin
               o_ready_s = 1'b1;
            end
         end
         KEYEXP: begin
            rk_s = fwd_s;
            if (rnd_r == 4'd10) begin
               cache_key_s = ckey_r;
               cache_k10_s = fwd_s;
               cache_vld_s = 1'b1;
               rnd_s       = 4'd10;
               state_s     = DEC;
            end else begin
               rnd_s = rnd_r + 4'd1;
            end
         end
         DEC: begin
            // round 10 is the initial key add only
            if (rnd_r == 4'd10) begin
               st_s = st_r ^ rk_r;
            end else begin
               st_s = round_s;
            end
            // k0 is the last key needed, so the schedule stops stepping at round 0
            if (last_s) begin
               o_data_s  = round_s;
               o_valid_s = 1'b1;
               state_s   = DONE;
            end else begin
               rk_s  = inv_s;
               rnd_s = rnd_r - 4'd1;
            end
         end
         DONE: begin
            if (i_ready) begin
               o_valid_s = 1'b0;
               o_ready_s = 1'b1;
               state_s   = IDLE;
            end else begin
               o_valid_s = 1'b1;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // datapath, cache and output registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         st_r        <= 128'h0;
         rk_r        <= 128'h0;
         rnd_r       <= 4'd0;
         ckey_r      <= 128'h0;
         cache_key_r <= 128'h0;
         cache_k10_r <= 128'h0;
         cache_vld_r <= 1'b0;
         o_data_r    <= 128'h0;
         o_valid_r   <= 1'b0;
         o_ready_r   <= 1'b1;
      end else begin
         st_r        <= st_s;
         rk_r        <= rk_s;
         rnd_r       <= rnd_s;
         ckey_r      <= ckey_s;
         cache_key_r <= cache_key_s;
         cache_k10_r <= cache_k10_s;
         cache_vld_r <= cache_vld_s;
         o_data_r    <= o_data_s;
         o_valid_r   <= o_valid_s;
         o_ready_r   <= o_ready_s;
      end
   end

   assign o_data  = o_data_r;
   assign o_valid = o_valid_r;
   assign o_ready = o_ready_r;

endmodule

// File: tb/tb_aes_decrypt_core.sv
// tb_aes_decrypt_core: directed bench for aes_decrypt_core.
// FIPS-197 vectors, cache hit/miss latency, backpressure, reset mid-decrypt,
// and random blocks whose ciphertext comes from a forward-cipher model here.
module tb_aes_decrypt_core;

   logic         i_clk;
   logic         i_rst;
   logic         i_valid;
   logic         o_ready;
   logic [127:0] i_data;
   logic [127:0] i_key;
   logic         o_valid;
   logic         i_ready;
   logic [127:0] o_data;

   int n_tests;
   int n_fail;

   logic         mdl_vld;
   logic [127:0] mdl_key;
   logic [127:0] pool [4];
   logic [127:0] r_key, r_pt, r_ct;
   int           r_lat;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   logic [7:0] sbox_t [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   aes_decrypt_core dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_data  (i_data),
      .i_key   (i_key),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_data  (o_data)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   function automatic logic [7:0] tb_xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // forward AES-128 encryption, used to build random test vectors
   function automatic logic [127:0] tb_encrypt(input logic [127:0] pt, input logic [127:0] key);
      logic [127:0] k, s, t;
      logic [31:0]  w;
      logic [7:0]   rc, a0, a1, a2, a3;
      k  = key;
      s  = pt ^ key;
      rc = 8'h01;
      for (int r = 1; r <= 10; r++) begin
         w = {k[23:0], k[31:24]};
         w = {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]} ^ {rc, 24'h000000};
         k[127:96] = k[127:96] ^ w;
         k[95:64]  = k[95:64]  ^ k[127:96];
         k[63:32]  = k[63:32]  ^ k[95:64];
         k[31:0]   = k[31:0]   ^ k[63:32];
         rc = tb_xt(rc);
         for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
               t[127-8*(rr+4*c) -: 8] = sbox_t[s[127-8*(rr+4*((c+rr)%4)) -: 8]];
         if (r != 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = t[127-32*c -: 8]; a1 = t[119-32*c -: 8];
               a2 = t[111-32*c -: 8]; a3 = t[103-32*c -: 8];
               t[127-32*c -: 32] = {tb_xt(a0) ^ tb_xt(a1) ^ a1 ^ a2 ^ a3,
                                    a0 ^ tb_xt(a1) ^ tb_xt(a2) ^ a2 ^ a3,
                                    a0 ^ a1 ^ tb_xt(a2) ^ tb_xt(a3) ^ a3,
                                    tb_xt(a0) ^ a0 ^ a1 ^ a2 ^ tb_xt(a3)};
            end
         end
         s = t ^ k;
      end
      return s;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // offer one block, scramble inputs while busy, wait for o_valid and check it
   task automatic run_block(input string tag, input logic [127:0] key, input logic [127:0] ct,
                            input logic [127:0] exp_pt, input int exp_lat);
      int lat;
      chk({tag, "_ready_idle"}, 128'(o_ready), 128'h1);
      i_valid = 1'b1;
      i_key   = key;
      i_data  = ct;
      @(posedge i_clk); #1;
      chk({tag, "_ready_busy"}, 128'(o_ready), 128'h0);
      lat = 0;
      while (o_valid !== 1'b1 && lat < 40) begin
         i_valid = 1'b1;
         i_key   = {$urandom, $urandom, $urandom, $urandom};
         i_data  = {$urandom, $urandom, $urandom, $urandom};
         @(posedge i_clk); #1;
         lat++;
      end
      i_valid = 1'b0;
      chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
      chk({tag, "_pt"}, o_data, exp_pt);
      mdl_vld = 1'b1;
      mdl_key = key;
   endtask

   task automatic handshake(input string tag);
      i_ready = 1'b1;
      i_valid = 1'b0;
      @(posedge i_clk); #1;
      i_ready = 1'b0;
      chk({tag, "_hs_valid"}, 128'(o_valid), 128'h0);
      chk({tag, "_hs_ready"}, 128'(o_ready), 128'h1);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      mdl_vld = 1'b0;
      mdl_key = 128'h0;
      i_rst   = 1'b1;
      i_valid = 1'b0;
      i_ready = 1'b0;
      i_data  = 128'h0;
      i_key   = 128'h0;
      repeat (2) @(posedge i_clk);
      #1;
      chk("reset_valid", 128'(o_valid), 128'h0);
      chk("reset_ready", 128'(o_ready), 128'h1);
      chk("reset_data", o_data, 128'h0);
      i_rst = 1'b0;
      @(posedge i_clk); #1;

      // FIPS-197 C.1, cold cache then warm cache
      run_block("c1_cold", C1_KEY, C1_CT, C1_PT, 21);
      chk("c1_cache_k10", dut.cache_k10_r, C1_K10);
      handshake("c1_cold");
      run_block("c1_hot", C1_KEY, C1_CT, C1_PT, 11);
      handshake("c1_hot");

      // FIPS-197 Appendix B: new key forces a miss
      run_block("fips_b", B_KEY, B_CT, B_PT, 21);
      chk("b_cache_k10", dut.cache_k10_r, B_K10);

      // backpressure in DONE with i_valid pulses that must be ignored
      for (int i = 0; i < 5; i++) begin
         i_valid = (i % 2 == 0) ? 1'b1 : 1'b0;
         i_data  = ~B_CT;
         i_key   = ~B_KEY;
         @(posedge i_clk); #1;
         chk("bp_data", o_data, B_PT);
         chk("bp_valid", 128'(o_valid), 128'h1);
         chk("bp_ready", 128'(o_ready), 128'h0);
      end
      i_valid = 1'b0;
      handshake("fips_b");

      // reset during the fifth decrypt cycle of a cold C.1 block
      i_valid = 1'b1;
      i_key   = C1_KEY;
      i_data  = C1_CT;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      repeat (14) @(posedge i_clk);
      #1;
      i_rst = 1'b1;
      #1;
      chk("rst_mid_valid", 128'(o_valid), 128'h0);
      chk("rst_mid_data", o_data, 128'h0);
      chk("rst_mid_ready", 128'(o_ready), 128'h1);
      @(posedge i_clk); #1;
      i_rst   = 1'b0;
      mdl_vld = 1'b0;
      run_block("c1_after_rst", C1_KEY, C1_CT, C1_PT, 21);
      handshake("c1_after_rst");

      // random blocks over a small key pool so hits and misses both occur
      for (int i = 0; i < 4; i++) pool[i] = {$urandom, $urandom, $urandom, $urandom};
      for (int n = 0; n < 200; n++) begin
         r_key = pool[$urandom_range(0, 3)];
         r_pt  = {$urandom, $urandom, $urandom, $urandom};
         r_ct  = tb_encrypt(r_pt, r_key);
         r_lat = (mdl_vld && r_key == mdl_key) ? 11 : 21;
         run_block("rand", r_key, r_ct, r_pt, r_lat);
         handshake("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
